// File: rtl/cim_mem_arb.sv
// Arbitrated single-port memory: N_REQ requesters share one DEPTH x N_STORAGE array.
// Round-robin or fixed-priority grant, 1-cycle registered read, sticky access-error flag.
module cim_mem_arb #(
  parameter int unsigned       N_STORAGE  = 16,
  parameter int unsigned       DEPTH      = 528,
  parameter int unsigned       N_REQ      = 3,
  parameter int unsigned       RR_MODE    = 1,
  parameter logic [N_REQ-1:0]  WRITE_MASK = 3'b011,
  localparam int unsigned      AW         = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ-1:0]             wen,
  input  logic [N_REQ*AW-1:0]          addr,
  input  logic [N_REQ*N_STORAGE-1:0]   wdata,
  output logic [N_REQ-1:0]             gnt,
  output logic [N_STORAGE-1:0]         rdata,
  output logic [N_REQ-1:0]             rvalid,
  output logic                         err,
  input  logic                         err_clr
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_STORAGE-1:0] r_mem [DEPTH];
  logic [PW-1:0]        r_ptr;
  logic [N_STORAGE-1:0] r_rdata;
  logic [N_REQ-1:0]     r_rvalid;
  logic                 r_err;

  logic [N_REQ-1:0]     w_gnt;
  logic                 w_found;
  logic                 w_any;
  logic [PW-1:0]        w_sel;
  logic                 w_wen;
  logic                 w_wmask;
  logic [AW-1:0]        w_addr;
  logic [N_STORAGE-1:0] w_wdata;
  logic                 w_oob;
  logic                 w_wr_ok;
  logic                 w_rd_ok;
  logic                 w_err_ev;

  // Round-robin: first pass looks strictly above the pointer, second pass wraps to the bottom.
  always_comb begin
    w_gnt   = '0;
    w_found = 1'b0;
    if (RR_MODE != 0) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!w_found && req[i] && (PW'(i) > r_ptr)) begin
          w_gnt[i] = 1'b1;
          w_found  = 1'b1;
        end
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req[i]) begin
        w_gnt[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
    if (rst) begin
      w_gnt = '0;
    end
  end

  always_comb begin
    w_sel   = '0;
    w_wen   = 1'b0;
    w_wmask = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel   = PW'(i);
        w_wen   = wen[i];
        w_wmask = WRITE_MASK[i];
        w_addr  = addr[i*AW +: AW];
        w_wdata = wdata[i*N_STORAGE +: N_STORAGE];
      end
    end
  end

  assign w_any    = |w_gnt;
  assign w_oob    = 32'(w_addr) >= DEPTH;
  assign w_wr_ok  = w_any & w_wen & w_wmask & ~w_oob;
  assign w_rd_ok  = w_any & ~w_wen & ~w_oob;
  assign w_err_ev = w_any & (w_oob | (w_wen & ~w_wmask));

  // Array is intentionally not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[w_addr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= PW'(N_REQ - 1);
      r_rdata  <= '0;
      r_rvalid <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_any) begin
        r_ptr <= w_sel;
      end
      if (w_rd_ok) begin
        r_rdata <= r_mem[w_addr];
      end
      r_rvalid <= w_rd_ok ? w_gnt : '0;
      // A new error wins over a same-cycle clear.
      if (w_err_ev) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign gnt    = w_gnt;
  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign err    = r_err;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
    else $error("gnt is not one-hot-or-zero");
  a_rvalid_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(rvalid))
    else $error("rvalid is not one-hot-or-zero");

endmodule

// File: tb/tb_cim_mem_arb.sv
// Bench for cim_mem_arb: a round-robin and a fixed-priority instance share stimulus and are
// compared against a behavioural model (modular pointer scan, associative-array memory).
module tb_cim_mem_arb;

  localparam int unsigned NS    = 16;
  localparam int unsigned DEPTH = 528;
  localparam int unsigned NR    = 3;
  localparam int unsigned AW    = 10;
  localparam logic [2:0]  WMASK = 3'b011;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, wen;
  logic [29:0] addr;
  logic [47:0] wdata;
  logic        err_clr;
  logic [2:0]  gnt_rr, rvalid_rr, gnt_fp, rvalid_fp;
  logic [15:0] rdata_rr, rdata_fp;
  logic        err_rr, err_fp;

  int n_checks = 0;
  int n_errors = 0;

  // Model state, index 0 = round-robin instance, 1 = fixed-priority instance.
  int          m_ptr    [2];
  logic [2:0]  m_rvalid [2];
  logic [15:0] m_rdata  [2];
  bit          m_known  [2];
  logic        m_err    [2];
  logic [15:0] m_mem    [int];

  cim_mem_arb #(.N_STORAGE(16), .DEPTH(528), .N_REQ(3), .RR_MODE(1), .WRITE_MASK(3'b011))
    u_dut_rr (.clk(clk), .rst(rst), .req(req), .wen(wen), .addr(addr), .wdata(wdata),
              .gnt(gnt_rr), .rdata(rdata_rr), .rvalid(rvalid_rr), .err(err_rr),
              .err_clr(err_clr));

  cim_mem_arb #(.N_STORAGE(16), .DEPTH(528), .N_REQ(3), .RR_MODE(0), .WRITE_MASK(3'b011))
    u_dut_fp (.clk(clk), .rst(rst), .req(req), .wen(wen), .addr(addr), .wdata(wdata),
              .gnt(gnt_fp), .rdata(rdata_fp), .rvalid(rvalid_fp), .err(err_fp),
              .err_clr(err_clr));

  always #5 clk = ~clk;

  function automatic logic [2:0] exp_gnt(input int d);
    if (req == 3'b000) return 3'b000;
    if (d == 0) begin
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_ptr[0] + k) % NR;
        if (req[c]) return 3'(1 << c);
      end
    end else begin
      for (int c = 0; c < NR; c++) begin
        if (req[c]) return 3'(1 << c);
      end
    end
    return 3'b000;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d]    = NR - 1;
      m_rvalid[d] = 3'b000;
      m_rdata[d]  = 16'h0000;
      m_known[d]  = 1'b1;
      m_err[d]    = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      logic [2:0] g;
      int         ch;
      int         a;
      bit         ev;
      g           = exp_gnt(d);
      ev          = 1'b0;
      m_rvalid[d] = 3'b000;
      if (g != 3'b000) begin
        ch = g[0] ? 0 : (g[1] ? 1 : 2);
        a  = int'(addr[ch*AW +: AW]);
        if (a >= DEPTH) begin
          ev = 1'b1;
        end else if (wen[ch]) begin
          if (WMASK[ch]) m_mem[d*2048 + a] = wdata[ch*NS +: NS];
          else ev = 1'b1;
        end else begin
          m_rvalid[d] = g;
          if (m_mem.exists(d*2048 + a)) begin
            m_rdata[d] = m_mem[d*2048 + a];
            m_known[d] = 1'b1;
          end else begin
            m_known[d] = 1'b0;
          end
        end
        m_ptr[d] = ch;
      end
      if (ev) m_err[d] = 1'b1;
      else if (err_clr) m_err[d] = 1'b0;
    end
  endtask

  // Inputs only change at edge+1 or later, so the model sees what the DUT sampled.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_idle();
    req     = 3'b000;
    wen     = 3'b000;
    err_clr = 1'b0;
  endtask

  task automatic set_ch(input int c, input logic w, input logic [9:0] a, input logic [15:0] dt);
    req[c]           = 1'b1;
    wen[c]           = w;
    addr[c*AW +: AW] = a;
    wdata[c*NS +: NS] = dt;
  endtask

  task automatic test_reset();
    req = 3'b111;
    repeat (2) tick();
    #1;
    n_checks++;
    if (gnt_rr !== 3'b000) begin
      n_errors++; $display("FAIL reset_gnt_rr: got %b expected 000", gnt_rr);
    end
    n_checks++;
    if (gnt_fp !== 3'b000) begin
      n_errors++; $display("FAIL reset_gnt_fp: got %b expected 000", gnt_fp);
    end
    n_checks++;
    if (rvalid_rr !== 3'b000) begin
      n_errors++; $display("FAIL reset_rvalid: got %b expected 000", rvalid_rr);
    end
    n_checks++;
    if (rdata_rr !== 16'h0000 || rdata_fp !== 16'h0000) begin
      n_errors++; $display("FAIL reset_rdata: got %h/%h expected 0000", rdata_rr, rdata_fp);
    end
    n_checks++;
    if (err_rr !== 1'b0 || err_fp !== 1'b0) begin
      n_errors++; $display("FAIL reset_err: got %b/%b expected 0", err_rr, err_fp);
    end
    rst = 1'b0;
    drive_idle();
  endtask

  task automatic test_round_robin();
    drive_idle();
    set_ch(0, 1'b0, 10'd40, 16'h0);
    set_ch(1, 1'b0, 10'd41, 16'h0);
    set_ch(2, 1'b0, 10'd42, 16'h0);
    for (int k = 0; k < 6; k++) begin
      logic [2:0] e;
      e = 3'b001 << (k % 3);
      #1;
      n_checks++;
      if (gnt_rr !== e) begin
        n_errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt_rr, e);
      end
      n_checks++;
      if (gnt_fp !== 3'b001) begin
        n_errors++; $display("FAIL fp_gnt_all[%0d]: got %b expected 001", k, gnt_fp);
      end
      tick();
      n_checks++;
      if (rvalid_rr !== e) begin
        n_errors++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", k, rvalid_rr, e);
      end
    end
  endtask

  task automatic test_fixed_priority();
    for (int k = 0; k < 5; k++) begin
      logic [2:0] e;
      req = (k < 2) ? 3'b110 : 3'b111;
      e   = (k < 2) ? 3'b010 : 3'b001;
      #1;
      n_checks++;
      if (gnt_fp !== e) begin
        n_errors++; $display("FAIL fp_gnt[%0d]: got %b expected %b", k, gnt_fp, e);
      end
      n_checks++;
      if (gnt_rr !== exp_gnt(0)) begin
        n_errors++; $display("FAIL rr_gnt_mix[%0d]: got %b expected %b", k, gnt_rr, exp_gnt(0));
      end
      tick();
      n_checks++;
      if (rvalid_fp !== e) begin
        n_errors++; $display("FAIL fp_rvalid[%0d]: got %b expected %b", k, rvalid_fp, e);
      end
    end
  endtask

  task automatic test_write_read();
    drive_idle();
    set_ch(0, 1'b1, 10'd5, 16'hBEEF);
    #1;
    n_checks++;
    if (gnt_rr !== 3'b001 || gnt_fp !== 3'b001) begin
      n_errors++; $display("FAIL wr_gnt: got %b/%b expected 001", gnt_rr, gnt_fp);
    end
    tick();
    n_checks++;
    if (rvalid_rr !== 3'b000) begin
      n_errors++; $display("FAIL wr_rvalid: got %b expected 000", rvalid_rr);
    end
    drive_idle();
    set_ch(1, 1'b0, 10'd5, 16'h0);
    #1;
    n_checks++;
    if (gnt_rr !== 3'b010) begin
      n_errors++; $display("FAIL rd_gnt: got %b expected 010", gnt_rr);
    end
    tick();
    n_checks++;
    if (rvalid_rr !== 3'b010 || rdata_rr !== 16'hBEEF) begin
      n_errors++; $display("FAIL rd_data_rr: got %b/%h expected 010/beef", rvalid_rr, rdata_rr);
    end
    n_checks++;
    if (rvalid_fp !== 3'b010 || rdata_fp !== 16'hBEEF) begin
      n_errors++; $display("FAIL rd_data_fp: got %b/%h expected 010/beef", rvalid_fp, rdata_fp);
    end
    drive_idle();
    tick();
    n_checks++;
    if (rvalid_rr !== 3'b000 || rdata_rr !== 16'hBEEF) begin
      n_errors++; $display("FAIL rd_hold: got %b/%h expected 000/beef", rvalid_rr, rdata_rr);
    end
  endtask

  task automatic test_write_mask();
    drive_idle();
    set_ch(0, 1'b1, 10'd7, 16'h5555);
    tick();
    drive_idle();
    set_ch(2, 1'b1, 10'd7, 16'h1234);
    #1;
    n_checks++;
    if (gnt_rr !== 3'b100) begin
      n_errors++; $display("FAIL mask_gnt: got %b expected 100", gnt_rr);
    end
    tick();
    n_checks++;
    if (err_rr !== 1'b1 || err_fp !== 1'b1 || rvalid_rr !== 3'b000) begin
      n_errors++; $display("FAIL mask_err: got %b/%b rvalid %b expected 1/1 000",
                           err_rr, err_fp, rvalid_rr);
    end
    drive_idle();
    set_ch(1, 1'b0, 10'd7, 16'h0);
    tick();
    n_checks++;
    if (rdata_rr !== 16'h5555 || rdata_fp !== 16'h5555 || err_rr !== 1'b1) begin
      n_errors++; $display("FAIL mask_readback: got %h/%h err %b expected 5555 err 1",
                           rdata_rr, rdata_fp, err_rr);
    end
    drive_idle();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++;
    if (err_rr !== 1'b0 || err_fp !== 1'b0) begin
      n_errors++; $display("FAIL mask_clr: got %b/%b expected 0", err_rr, err_fp);
    end
  endtask

  task automatic test_out_of_range();
    drive_idle();
    set_ch(1, 1'b0, 10'd528, 16'h0);
    err_clr = 1'b1;
    tick();
    n_checks++;
    if (rvalid_rr !== 3'b000 || rvalid_fp !== 3'b000) begin
      n_errors++; $display("FAIL oor_rvalid: got %b/%b expected 000", rvalid_rr, rvalid_fp);
    end
    n_checks++;
    if (err_rr !== 1'b1 || err_fp !== 1'b1) begin
      n_errors++; $display("FAIL oor_err_vs_clr: got %b/%b expected 1", err_rr, err_fp);
    end
    n_checks++;
    if (rdata_rr !== 16'h5555) begin
      n_errors++; $display("FAIL oor_rdata_hold: got %h expected 5555", rdata_rr);
    end
    drive_idle();
    err_clr = 1'b1;
    tick();
    drive_idle();
    set_ch(0, 1'b1, 10'd527, 16'hA5A5);
    tick();
    drive_idle();
    set_ch(1, 1'b0, 10'd527, 16'h0);
    tick();
    n_checks++;
    if (rvalid_rr !== 3'b010 || rdata_rr !== 16'hA5A5 || err_rr !== 1'b0) begin
      n_errors++; $display("FAIL top_addr: got %b/%h err %b expected 010/a5a5 err 0",
                           rvalid_rr, rdata_rr, err_rr);
    end
    drive_idle();
    set_ch(0, 1'b1, 10'd1023, 16'hDEAD);
    tick();
    n_checks++;
    if (err_rr !== 1'b1) begin
      n_errors++; $display("FAIL oor_write_err: got %b expected 1", err_rr);
    end
    drive_idle();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive_idle();
    set_ch(0, 1'b1, 10'd20, 16'h1357);
    tick();
    drive_idle();
    set_ch(1, 1'b0, 10'd20, 16'h0);
    #1;
    n_checks++;
    if (gnt_rr !== 3'b010) begin
      n_errors++; $display("FAIL mid_gnt_pre: got %b expected 010", gnt_rr);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (gnt_rr !== 3'b000 || gnt_fp !== 3'b000) begin
      n_errors++; $display("FAIL mid_gnt_rst: got %b/%b expected 000", gnt_rr, gnt_fp);
    end
    tick();
    n_checks++;
    if (rvalid_rr !== 3'b000 || rdata_rr !== 16'h0000 || err_rr !== 1'b0) begin
      n_errors++; $display("FAIL mid_rst_state: got %b/%h err %b expected 000/0000 err 0",
                           rvalid_rr, rdata_rr, err_rr);
    end
    rst = 1'b0;
    drive_idle();
    set_ch(0, 1'b0, 10'd20, 16'h0);
    set_ch(1, 1'b0, 10'd21, 16'h0);
    set_ch(2, 1'b0, 10'd22, 16'h0);
    #1;
    n_checks++;
    if (gnt_rr !== 3'b001) begin
      n_errors++; $display("FAIL mid_rr_restart: got %b expected 001", gnt_rr);
    end
    tick();
    n_checks++;
    if (rvalid_rr !== 3'b001 || rdata_rr !== 16'h1357) begin
      n_errors++; $display("FAIL mid_data_kept: got %b/%h expected 001/1357", rvalid_rr, rdata_rr);
    end
    drive_idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      req     = 3'($urandom_range(0, 7));
      wen     = 3'($urandom_range(0, 7));
      err_clr = ($urandom_range(0, 7) == 0);
      for (int c = 0; c < NR; c++) begin
        int r;
        r = $urandom_range(0, 9);
        addr[c*AW +: AW]  = (r < 8) ? 10'($urandom_range(0, 15)) :
                            (r == 8) ? 10'($urandom_range(524, 527)) :
                                       10'($urandom_range(528, 1023));
        wdata[c*NS +: NS] = 16'($urandom);
      end
      #1;
      n_checks++;
      if (gnt_rr !== exp_gnt(0) || gnt_fp !== exp_gnt(1)) begin
        n_errors++; $display("FAIL rnd_gnt[%0d]: got %b/%b expected %b/%b",
                             n, gnt_rr, gnt_fp, exp_gnt(0), exp_gnt(1));
      end
      tick();
      n_checks++;
      if (rvalid_rr !== m_rvalid[0] || rvalid_fp !== m_rvalid[1]) begin
        n_errors++; $display("FAIL rnd_rvalid[%0d]: got %b/%b expected %b/%b",
                             n, rvalid_rr, rvalid_fp, m_rvalid[0], m_rvalid[1]);
      end
      n_checks++;
      if (err_rr !== m_err[0] || err_fp !== m_err[1]) begin
        n_errors++; $display("FAIL rnd_err[%0d]: got %b/%b expected %b/%b",
                             n, err_rr, err_fp, m_err[0], m_err[1]);
      end
      if (m_known[0]) begin
        n_checks++;
        if (rdata_rr !== m_rdata[0]) begin
          n_errors++; $display("FAIL rnd_rdata_rr[%0d]: got %h expected %h", n, rdata_rr, m_rdata[0]);
        end
      end
      if (m_known[1]) begin
        n_checks++;
        if (rdata_fp !== m_rdata[1]) begin
          n_errors++; $display("FAIL rnd_rdata_fp[%0d]: got %h expected %h", n, rdata_fp, m_rdata[1]);
        end
      end
    end
    drive_idle();
  endtask

  initial begin
    rst   = 1'b1;
    addr  = '0;
    wdata = '0;
    drive_idle();
    model_reset();
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_write_read();
    test_write_mask();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
